axi_burst_master: RTL and testbench

- AXI4 burst traffic generator and checker; sits directly upstream of the team's AXI slave with skid buffers and drives its S_* ports.
- On a start pulse it performs a series of INCR write bursts with a deterministic data pattern, then reads the same region back.
- It compares every read beat and response against expectations and reports an error count.
- Used for throughput bring-up and as a self-checking stimulus source.

---
 rtl/axi_burst_master.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// AXI4 burst traffic generator and checker: writes INCR bursts of a counting pattern,
// reads the same region back and counts bad read beats and bad responses.
module axi_burst_master #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [7:0]            i_len,
    input  logic [7:0]            i_nburst,
    input  logic [DATA_WIDTH-1:0] i_seed,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [15:0]           o_err_cnt,
    output logic [ID_WIDTH-1:0]   M_AWID,
    output logic [ADDR_WIDTH-1:0] M_AWADDR,
    output logic [7:0]            M_AWLEN,
    output logic [2:0]            M_AWSIZE,
    output logic [1:0]            M_AWBURST,
    output logic                  M_AWLOCK,
    output logic [3:0]            M_AWCACHE,
    output logic [2:0]            M_AWPROT,
    output logic [3:0]            M_AWQOS,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,
    output logic [DATA_WIDTH-1:0] M_WDATA,
    output logic [STRB_WIDTH-1:0] M_WSTRB,
    output logic                  M_WLAST,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    input  logic [ID_WIDTH-1:0]   M_BID,
    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,
    output logic [ID_WIDTH-1:0]   M_ARID,
    output logic [ADDR_WIDTH-1:0] M_ARADDR,
    output logic [7:0]            M_ARLEN,
    output logic [2:0]            M_ARSIZE,
    output logic [1:0]            M_ARBURST,
    output logic                  M_ARLOCK,
    output logic [3:0]            M_ARCACHE,
    output logic [2:0]            M_ARPROT,
    output logic [3:0]            M_ARQOS,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    input  logic [ID_WIDTH-1:0]   M_RID,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RLAST,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
);

    localparam int unsigned LSB = $clog2(STRB_WIDTH);

    typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StDone} state_e;

    state_e                st;
    logic [7:0]            len_q, nburst_q, b_q, k_q;
    logic [DATA_WIDTH-1:0] seed_q, pat_q;
    logic [ADDR_WIDTH-1:0] base_q, addr_q;

    logic [ADDR_WIDTH-1:0] base_in, step, addr_nxt;
    logic [8:0]            b_nxt;
    logic                  more, b_bad, r_bad, err_inc;

    assign M_AWLEN   = len_q;
    assign M_ARLEN   = len_q;
    assign M_AWSIZE  = 3'(LSB);
    assign M_ARSIZE  = 3'(LSB);
    assign M_AWBURST = 2'b01;
    assign M_ARBURST = 2'b01;
    assign M_AWLOCK  = 1'b0;
    assign M_ARLOCK  = 1'b0;
    assign M_AWCACHE = 4'd0;
    assign M_ARCACHE = 4'd0;
    assign M_AWPROT  = 3'd0;
    assign M_ARPROT  = 3'd0;
    assign M_AWQOS   = 4'd0;
    assign M_ARQOS   = 4'd0;
    assign M_WSTRB   = '1;

    assign base_in  = i_base_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
    // Bursts are contiguous; the address simply wraps at 2^ADDR_WIDTH.
    assign step     = ADDR_WIDTH'((32'(len_q) + 32'd1) * STRB_WIDTH);
    assign addr_nxt = addr_q + step;
    assign b_nxt    = {1'b0, b_q} + 9'd1;
    assign more     = b_nxt < {1'b0, nburst_q};

    // pat_q tracks the expected data of the current read beat.
    assign b_bad   = (M_BRESP != 2'b00) || (M_BID != M_AWID);
    assign r_bad   = (M_RDATA != pat_q) || (M_RRESP != 2'b00) || (M_RID != M_ARID) ||
                     (M_RLAST != (k_q == len_q));
    assign err_inc = (st == StB && M_BVALID && M_BREADY && b_bad) ||
                     (st == StR && M_RVALID && M_RREADY && r_bad);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            st        <= StIdle;
            len_q     <= '0;
            nburst_q  <= '0;
            b_q       <= '0;
            k_q       <= '0;
            seed_q    <= '0;
            pat_q     <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err_cnt <= '0;
            M_AWID    <= '0;
            M_AWADDR  <= '0;
            M_AWVALID <= 1'b0;
            M_WDATA   <= '0;
            M_WLAST   <= 1'b0;
            M_WVALID  <= 1'b0;
            M_BREADY  <= 1'b0;
            M_ARID    <= '0;
            M_ARADDR  <= '0;
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (err_inc && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
            case (st)
                StIdle: if (i_start) begin
                    o_busy    <= 1'b1;
                    o_err_cnt <= '0;
                    len_q     <= i_len;
                    nburst_q  <= i_nburst;
                    seed_q    <= i_seed;
                    pat_q     <= i_seed;
                    base_q    <= base_in;
                    addr_q    <= base_in;
                    b_q       <= '0;
                    if (i_nburst == 8'd0) begin
                        st <= StDone;
                    end else begin
                        st        <= StAw;
                        M_AWVALID <= 1'b1;
                        M_AWADDR  <= base_in;
                        M_AWID    <= '0;
                    end
                end
                StAw: if (M_AWVALID && M_AWREADY) begin
                    M_AWVALID <= 1'b0;
                    M_WVALID  <= 1'b1;
                    M_WDATA   <= pat_q;
                    M_WLAST   <= (len_q == 8'd0);
                    pat_q     <= pat_q + DATA_WIDTH'(1);
                    k_q       <= '0;
                    st        <= StW;
                end
                StW: if (M_WVALID && M_WREADY) begin
                    if (M_WLAST) begin
                        M_WVALID <= 1'b0;
                        M_BREADY <= 1'b1;
                        st       <= StB;
                    end else begin
                        M_WDATA <= pat_q;
                        M_WLAST <= (k_q + 8'd1 == len_q);
                        pat_q   <= pat_q + DATA_WIDTH'(1);
                        k_q     <= k_q + 8'd1;
                    end
                end
                StB: if (M_BVALID && M_BREADY) begin
                    M_BREADY <= 1'b0;
                    if (more) begin
                        b_q       <= b_nxt[7:0];
                        addr_q    <= addr_nxt;
                        M_AWADDR  <= addr_nxt;
                        M_AWID    <= ID_WIDTH'(b_nxt);
                        M_AWVALID <= 1'b1;
                        st        <= StAw;
                    end else begin
                        b_q       <= '0;
                        addr_q    <= base_q;
                        pat_q     <= seed_q;
                        M_ARADDR  <= base_q;
                        M_ARID    <= '0;
                        M_ARVALID <= 1'b1;
                        st        <= StAr;
                    end
                end
                StAr: if (M_ARVALID && M_ARREADY) begin
                    M_ARVALID <= 1'b0;
                    M_RREADY  <= 1'b1;
                    k_q       <= '0;
                    st        <= StR;
                end
                // Beat count, not RLAST, terminates the burst.
                StR: if (M_RVALID && M_RREADY) begin
                    pat_q <= pat_q + DATA_WIDTH'(1);
                    if (k_q == len_q) begin
                        M_RREADY <= 1'b0;
                        if (more) begin
                            b_q       <= b_nxt[7:0];
                            addr_q    <= addr_nxt;
                            M_ARADDR  <= addr_nxt;
                            M_ARID    <= ID_WIDTH'(b_nxt);
                            M_ARVALID <= 1'b1;
                            st        <= StAr;
                        end else begin
                            st <= StDone;
                        end
                    end else begin
                        k_q <= k_q + 8'd1;
                    end
                end
                StDone: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    st     <= StIdle;
                end
                default: st <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: memory-backed AXI slave model with optional backpressure and
// fault injection; bursts are checked against address/data rules computed per burst and beat.
module tb_axi_burst_master;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned IW = 1;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b1;
    always #5 ACLK = ~ACLK;

    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [7:0]    i_len, i_nburst;
    logic [DW-1:0] i_seed;
    logic          o_busy, o_done;
    logic [15:0]   o_err_cnt;
    logic [IW-1:0] M_AWID, M_BID, M_ARID, M_RID;
    logic [AW-1:0] M_AWADDR, M_ARADDR;
    logic [7:0]    M_AWLEN, M_ARLEN;
    logic [2:0]    M_AWSIZE, M_ARSIZE, M_AWPROT, M_ARPROT;
    logic [1:0]    M_AWBURST, M_ARBURST, M_BRESP, M_RRESP;
    logic          M_AWLOCK, M_ARLOCK;
    logic [3:0]    M_AWCACHE, M_ARCACHE, M_AWQOS, M_ARQOS;
    logic          M_AWVALID, M_AWREADY, M_WLAST, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic          M_ARVALID, M_ARREADY, M_RLAST, M_RVALID, M_RREADY;
    logic [DW-1:0] M_WDATA, M_RDATA;
    logic [SW-1:0] M_WSTRB;

    axi_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_len(i_len), .i_nburst(i_nburst), .i_seed(i_seed), .o_busy(o_busy), .o_done(o_done),
        .o_err_cnt(o_err_cnt), .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN),
        .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST), .M_AWLOCK(M_AWLOCK),
        .M_AWCACHE(M_AWCACHE), .M_AWPROT(M_AWPROT), .M_AWQOS(M_AWQOS),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
        .M_WLAST(M_WLAST), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_BID(M_BID),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_ARID(M_ARID),
        .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
        .M_ARLOCK(M_ARLOCK), .M_ARCACHE(M_ARCACHE), .M_ARPROT(M_ARPROT), .M_ARQOS(M_ARQOS),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_RID(M_RID), .M_RDATA(M_RDATA),
        .M_RRESP(M_RRESP), .M_RLAST(M_RLAST), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    typedef struct {
        logic [AW-1:0] base;
        logic [7:0]    len;
        logic [7:0]    nburst;
        logic [DW-1:0] seed;
        bit            bp;
        bit            fi;
        int            exp_err;
    } vec_t;

    // Slave model: word memory, random READY/RVALID gaps when bp, faults when fi.
    bit            bp, fi;
    logic [DW-1:0] mem [256];
    logic [AW-1:0] w_addr, r_addr;
    logic [IW-1:0] aw_id_s, r_id_s;
    int            r_left, r_beat;

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            M_AWREADY <= 1'b0; M_WREADY <= 1'b0; M_ARREADY <= 1'b0;
            M_BVALID  <= 1'b0; M_BID <= '0; M_BRESP <= 2'b00;
            M_RVALID  <= 1'b0; M_RID <= '0; M_RRESP <= 2'b00; M_RLAST <= 1'b0; M_RDATA <= '0;
            w_addr <= '0; r_addr <= '0; aw_id_s <= '0; r_id_s <= '0; r_left <= 0; r_beat <= 0;
        end else begin
            M_AWREADY <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
            M_WREADY  <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
            M_ARREADY <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (M_AWVALID && M_AWREADY) begin
                w_addr  <= M_AWADDR;
                aw_id_s <= M_AWID;
            end
            if (M_WVALID && M_WREADY) begin
                mem[w_addr[9:2]] <= M_WDATA;
                w_addr <= w_addr + 10'd4;
                if (M_WLAST) begin
                    M_BVALID <= 1'b1;
                    M_BID    <= aw_id_s;
                    M_BRESP  <= (fi && aw_id_s == '0) ? 2'b10 : 2'b00;
                end
            end
            if (M_BVALID && M_BREADY) M_BVALID <= 1'b0;
            if (M_ARVALID && M_ARREADY) begin
                r_addr <= M_ARADDR;
                r_id_s <= M_ARID;
                r_left <= int'(M_ARLEN) + 1;
                r_beat <= 0;
            end else if (M_RVALID && M_RREADY) begin
                M_RVALID <= 1'b0;
                r_left   <= r_left - 1;
                r_addr   <= r_addr + 10'd4;
                r_beat   <= r_beat + 1;
            end else if (!M_RVALID && r_left > 0 && (!bp || $urandom_range(0, 2) != 0)) begin
                M_RVALID <= 1'b1;
                M_RDATA  <= mem[r_addr[9:2]] ^ ((fi && r_beat == 2) ? 32'd1 : 32'd0);
                M_RLAST  <= (r_left == 1) && !fi;
                M_RID    <= r_id_s;
                M_RRESP  <= 2'b00;
            end
        end
    end

    // Handshake log and VALID activity counter.
    logic [IW+AW-1:0] aw_q[$];
    logic [DW:0]      w_q[$];
    int               valid_cnt = 0;
    always @(posedge ACLK) begin
        if (ARESETn) begin
            if (M_AWVALID && M_AWREADY) aw_q.push_back({M_AWID, M_AWADDR});
            if (M_WVALID && M_WREADY) w_q.push_back({M_WLAST, M_WDATA});
            if (M_AWVALID || M_WVALID || M_ARVALID) valid_cnt <= valid_cnt + 1;
        end
    end

    // A stalled AW/W transfer must hold its payload into the next cycle.
    logic          p_aw, p_w, p_wlast;
    logic [AW-1:0] p_awaddr;
    logic [DW-1:0] p_wdata;
    int            stab_viol = 0;
    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            p_aw <= 1'b0;
            p_w  <= 1'b0;
        end else begin
            if (p_aw && !(M_AWVALID && M_AWADDR == p_awaddr)) stab_viol <= stab_viol + 1;
            if (p_w && !(M_WVALID && M_WDATA == p_wdata && M_WLAST == p_wlast))
                stab_viol <= stab_viol + 1;
            p_aw     <= M_AWVALID && !M_AWREADY;
            p_awaddr <= M_AWADDR;
            p_w      <= M_WVALID && !M_WREADY;
            p_wdata  <= M_WDATA;
            p_wlast  <= M_WLAST;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] m_addr(input vec_t v, input int b);
        int a;
        a = (int'(v.base) & ~3) + b * (int'(v.len) + 1) * int'(SW);
        return AW'(a % (1 << AW));
    endfunction

    function automatic logic [DW-1:0] m_data(input vec_t v, input int b, input int k);
        return v.seed + DW'(b * (int'(v.len) + 1) + k);
    endfunction

    task automatic start_op(input vec_t v);
        bp = v.bp;
        fi = v.fi;
        @(negedge ACLK);
        i_base_addr = v.base; i_len = v.len; i_nburst = v.nburst; i_seed = v.seed;
        i_start = 1'b1;
        @(negedge ACLK);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int c = 0; c < 20000 && !seen; c++) begin
            @(negedge ACLK);
            seen = o_done;
        end
        check({nm, ".done"}, 64'(seen), 64'd1);
    endtask

    task automatic run_test(input vec_t v, input string nm);
        int aw0, w0, nb, nl;
        aw0 = aw_q.size();
        w0  = w_q.size();
        start_op(v);
        check({nm, ".busy"}, 64'(o_busy), 64'd1);
        wait_done(nm);
        check({nm, ".busy_at_done"}, 64'(o_busy), 64'd0);
        check({nm, ".err_cnt"}, 64'(o_err_cnt), 64'(v.exp_err));
        nb = int'(v.nburst);
        nl = int'(v.len) + 1;
        check({nm, ".aw_count"}, 64'(aw_q.size() - aw0), 64'(nb));
        for (int b = 0; b < nb && aw0 + b < aw_q.size(); b++)
            check($sformatf("%s.aw%0d", nm, b), 64'(aw_q[aw0 + b]), 64'({IW'(b), m_addr(v, b)}));
        check({nm, ".w_count"}, 64'(w_q.size() - w0), 64'(nb * nl));
        for (int i = 0; i < nb * nl && w0 + i < w_q.size(); i++)
            check($sformatf("%s.w%0d", nm, i), 64'(w_q[w0 + i]),
                  64'({(i % nl) == nl - 1, m_data(v, i / nl, i % nl)}));
        check({nm, ".stable"}, 64'(stab_viol), 64'd0);
    endtask

    initial begin
        vec_t vecs[9];
        vec_t v;
        int   w0, aw0, vc;
        bit   seen;

        ARESETn = 1'b0;
        i_start = 1'b0; i_base_addr = '0; i_len = '0; i_nburst = '0; i_seed = '0;
        repeat (3) @(negedge ACLK);
        check("rst.busy", 64'(o_busy), 64'd0);
        check("rst.done", 64'(o_done), 64'd0);
        check("rst.err_cnt", 64'(o_err_cnt), 64'd0);
        check("rst.valids", 64'({M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}), 64'd0);
        check("const.size_burst_strb", 64'({M_AWSIZE, M_AWBURST, M_ARSIZE, M_ARBURST, M_WSTRB}),
              64'({3'd2, 2'b01, 3'd2, 2'b01, 4'hF}));
        ARESETn = 1'b1;

        vecs[0] = '{10'h000, 8'd0, 8'd1, 32'hA5A5_0000, 1'b0, 1'b0, 0};
        vecs[1] = '{10'h3F0, 8'd3, 8'd2, 32'h1234_5678, 1'b0, 1'b0, 0};
        vecs[2] = '{10'h100, 8'd7, 8'd4, 32'hDEAD_BEEF, 1'b1, 1'b0, 0};
        vecs[3] = '{10'h040, 8'd3, 8'd1, 32'h0000_0000, 1'b0, 1'b1, 3};
        vecs[4] = '{10'h3FF, 8'd1, 8'd3, 32'hFFFF_FFFE, 1'b1, 1'b0, 0};
        for (int i = 5; i < 9; i++)
            vecs[i] = '{AW'($urandom_range(0, 1023)), 8'($urandom_range(0, 15)),
                        8'($urandom_range(1, 4)), $urandom, 1'($urandom_range(0, 1)), 1'b0, 0};
        for (int i = 0; i < 9; i++) run_test(vecs[i], $sformatf("vec%0d", i));

        // Reset while beat 2 of 8 is on the W channel.
        v  = '{10'h080, 8'd7, 8'd1, 32'h1111_0000, 1'b0, 1'b0, 0};
        w0 = w_q.size();
        start_op(v);
        for (int c = 0; c < 200 && w_q.size() < w0 + 2; c++) @(negedge ACLK);
        check("rst_mid.beat2", 64'({M_WVALID, M_WDATA}), 64'({1'b1, 32'h1111_0002}));
        #1 ARESETn = 1'b0;
        #1;
        check("rst_mid.drop", 64'({M_WVALID, M_AWVALID, o_busy}), 64'd0);
        @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        check("rst_mid.err_cnt", 64'(o_err_cnt), 64'd0);
        run_test(v, "after_rst");

        // Zero bursts: done quickly and no VALID ever raised.
        v  = '{10'h010, 8'd3, 8'd0, 32'h5, 1'b0, 1'b0, 0};
        vc = valid_cnt;
        start_op(v);
        seen = 0;
        for (int c = 0; c < 2 && !seen; c++) begin
            @(negedge ACLK);
            seen = o_done;
        end
        check("nb0.done", 64'(seen), 64'd1);
        check("nb0.no_valid", 64'(valid_cnt - vc), 64'd0);
        check("nb0.busy", 64'(o_busy), 64'd0);

        // Second start while busy is ignored.
        v   = '{10'h200, 8'd1, 8'd2, 32'h7, 1'b0, 1'b0, 0};
        aw0 = aw_q.size();
        start_op(v);
        repeat (2) @(negedge ACLK);
        i_nburst = 8'd5;
        i_start  = 1'b1;
        @(negedge ACLK);
        i_start = 1'b0;
        wait_done("busy_start");
        repeat (20) @(negedge ACLK);
        check("busy_start.aw_count", 64'(aw_q.size() - aw0), 64'd2);
        check("busy_start.err_cnt", 64'(o_err_cnt), 64'd0);
        check("busy_start.idle", 64'(o_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
